// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path: frame-sequencer state
//   encoding, default oversample and inter-frame gap, parity mode constants
//   and a parity helper.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int GAP_CYCLES_DEFAULT = 2;

    // cfg_parity_odd encoding
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// ---------------------------------------------------------------------------
// uart_tx_sequencer
//   Transmit controller for one UART TX lane. Accepts a byte on a
//   valid/ready handshake, enables and programs the external baud-rate
//   generator, counts its oversample ticks and serialises
//   start / 8 data (LSB first) / optional parity / 1 or 2 stop bits on txd.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   cfg_div           baud divisor, sampled when a byte is accepted
//   cfg_parity_en     append a parity bit
//   cfg_parity_odd    1 = odd parity, 0 = even parity
//   cfg_stop2         1 = two stop bits
//   tx_valid/tx_data  byte offered by the host (held until tx_ready)
//   tx_ready          combinational: a byte would be accepted this cycle
//   tx_abort          drop the current frame, line returns to idle
//   baud_tick         oversample tick from the generator
//   baud_en           generator enable
//   baud_division     generator divisor
//   txd               serial line, idle high
//   busy              frame in progress
//   done              one-cycle pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_div,
    input  logic       cfg_parity_en,
    input  logic       cfg_parity_odd,
    input  logic       cfg_stop2,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       tx_abort,
    input  logic       baud_tick,
    output logic       baud_en,
    output logic [7:0] baud_division,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    shift;
    logic          lat_parity_en;
    logic          lat_parity_bit;
    logic          lat_stop2;

    // A zero divisor would leave the generator silent, so it is never taken.
    assign tx_ready = (state == IDLE) && (gap_cnt == '0) && (cfg_div != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            txd            <= 1'b1;
            baud_en        <= 1'b0;
            baud_division  <= 8'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            gap_cnt        <= GAP_RELOAD;
            shift          <= 8'd0;
            lat_parity_en  <= 1'b0;
            lat_parity_bit <= 1'b0;
            lat_stop2      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state == IDLE) begin
                // Gap countdown keeps baud_en low long enough for the
                // generator to see a clean enable edge on the next frame.
                if (gap_cnt != '0)
                    gap_cnt <= gap_cnt - 1'b1;

                if (tx_valid && tx_ready) begin
                    shift          <= tx_data;
                    lat_parity_en  <= cfg_parity_en;
                    lat_parity_bit <= parity_bit(tx_data, cfg_parity_odd);
                    lat_stop2      <= cfg_stop2;
                    baud_division  <= cfg_div;
                    baud_en        <= 1'b1;
                    busy           <= 1'b1;
                    txd            <= 1'b0;
                    state          <= START;
                    tick_cnt       <= '0;
                    bit_cnt        <= '0;
                end
            end else if (tx_abort) begin
                // Abort takes priority over any tick in the same cycle.
                state    <= IDLE;
                txd      <= 1'b1;
                baud_en  <= 1'b0;
                busy     <= 1'b0;
                gap_cnt  <= GAP_RELOAD;
                tick_cnt <= '0;
            end else if (baud_tick) begin
                if (tick_cnt != TICK_LAST) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    // Last tick of the current bit: present the next bit now.
                    tick_cnt <= '0;
                    case (state)
                        START: begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            txd     <= shift[0];
                        end
                        DATA: begin
                            if (bit_cnt == 3'd7) begin
                                if (lat_parity_en) begin
                                    state <= PARITY;
                                    txd   <= lat_parity_bit;
                                end else begin
                                    state <= STOP1;
                                    txd   <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shift   <= {1'b0, shift[7:1]};
                                txd     <= shift[1];
                            end
                        end
                        PARITY: begin
                            state <= STOP1;
                            txd   <= 1'b1;
                        end
                        STOP1: begin
                            if (lat_stop2) begin
                                state <= STOP2;
                                txd   <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                txd     <= 1'b1;
                                baud_en <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                gap_cnt <= GAP_RELOAD;
                            end
                        end
                        STOP2: begin
                            state   <= IDLE;
                            txd     <= 1'b1;
                            baud_en <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            gap_cnt <= GAP_RELOAD;
                        end
                        default: begin
                            // Unused encodings fall back to a safe idle line.
                            state   <= IDLE;
                            txd     <= 1'b1;
                            baud_en <= 1'b0;
                            busy    <= 1'b0;
                            gap_cnt <= GAP_RELOAD;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sequencer
//   Directed frames with hand-written bit patterns. The stimulus side pushes
//   each frame's expectation into a queue; a monitor pops it when busy rises,
//   checks txd on every baud tick, the divisor, baud_en, and the done pulse /
//   tick count when busy falls.
// ---------------------------------------------------------------------------
module tb_uart_tx_sequencer;
    import uart_pkg::*;

    localparam int OS  = 16;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cfg_div = 8'd3;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready;
    logic       tx_abort = 1'b0;
    logic       baud_tick = 1'b0;
    logic       baud_en;
    logic [7:0] baud_division;
    logic       txd;
    logic       busy;
    logic       done;

    uart_tx_sequencer #(.OVERSAMPLE(OS), .GAP_CYCLES(GAP)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_div        (cfg_div),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .tx_abort       (tx_abort),
        .baud_tick      (baud_tick),
        .baud_en        (baud_en),
        .baud_division  (baud_division),
        .txd            (txd),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bits;   // bit i = i-th bit on the line
        int          nbits;
        logic [7:0]  div;
        bit          killed; // aborted or reset: no done expected
    } frame_t;

    frame_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Free-running oversample tick, every 4th clock.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            baud_tick = (cyc % 4 == 0);
        end
    end

    // Monitor / scoreboard
    initial begin
        frame_t cur;
        int     n;
        int     bi;
        int     low_run;
        logic   busy_q;
        logic   en_q;
        bit     have;
        n = 0; low_run = 0; busy_q = 1'b0; en_q = 1'b0; have = 1'b0;
        cur.bits = '0; cur.nbits = 0; cur.div = '0; cur.killed = 1'b0;
        forever begin
            @(negedge clk);
            if (busy && !busy_q) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", exp_q.size(), 1);
                    have = 1'b0;
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                end
                n = 0;
            end
            if (busy && baud_tick && have) begin
                bi = n / OS;
                if (bi < cur.nbits) chk1("txd_bit", txd, cur.bits[bi[3:0]]);
                else                chk("frame_overrun", bi, cur.nbits - 1);
                chk1("baud_en_in_frame", baud_en, 1'b1);
                chk("baud_division", int'(baud_division), int'(cur.div));
                n++;
            end
            if (!busy && busy_q) begin
                if (have) begin
                    if (cur.killed) begin
                        chk1("no_done_on_kill", done, 1'b0);
                    end else begin
                        chk1("done_at_end", done, 1'b1);
                        chk("frame_ticks", n, cur.nbits * OS);
                    end
                end
                chk1("idle_txd", txd, 1'b1);
                chk1("idle_baud_en", baud_en, 1'b0);
                have = 1'b0;
            end else if (done) begin
                chk1("stray_done", done, 1'b0);
            end
            if (baud_en) begin
                if (!en_q) chk("gap_before_en", low_run >= GAP ? 1 : 0, 1);
                low_run = 0;
            end else begin
                low_run++;
            end
            busy_q = busy;
            en_q   = baud_en;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic send(input logic [7:0] d, input logic [7:0] div,
                        input logic pen, input logic podd, input logic st2,
                        input logic [11:0] bits, input int nb, input bit killed);
        frame_t f;
        bit ok;
        f.bits = bits; f.nbits = nb; f.div = div; f.killed = killed;
        exp_q.push_back(f);
        tx_data = d; cfg_div = div; cfg_parity_en = pen;
        cfg_parity_odd = podd; cfg_stop2 = st2; tx_valid = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk1("accept_timeout", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_frame();
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) chk1("frame_timeout", busy, 1'b0);
    endtask

    task automatic count_ticks(input int k);
        int c;
        c = 0;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (busy && baud_tick) c++;
            if (c == k) break;
        end
        if (c != k) chk("tick_wait_timeout", c, k);
    endtask

    task automatic ready_seq(input string name);
        @(negedge clk); chk1({name, "_ready0"}, tx_ready, 1'b0);
        @(negedge clk); chk1({name, "_ready1"}, tx_ready, 1'b0);
        @(negedge clk); chk1({name, "_ready2"}, tx_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk1("rst_txd", txd, 1'b1);
        chk1("rst_baud_en", baud_en, 1'b0);
        chk("rst_baud_division", int'(baud_division), 0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ready", tx_ready, 1'b0);
        @(posedge clk); #1; rst = 1'b0;
        ready_seq("post_reset");

        // 8N1 0xA5, cfg changes mid-frame are ignored
        @(posedge clk); #1;
        send(8'hA5, 8'd3, 1'b0, 1'b0, 1'b0, 12'b00_1101001010, 10, 1'b0);
        cfg_div = 8'd9; cfg_parity_en = 1'b1; cfg_stop2 = 1'b1;
        wait_frame();

        // 8E1 / 8O1 0xA5
        @(posedge clk); #1;
        send(8'hA5, 8'd3, 1'b1, PARITY_EVEN, 1'b0, 12'b0_10101001010, 11, 1'b0);
        wait_frame();
        @(posedge clk); #1;
        send(8'hA5, 8'd3, 1'b1, PARITY_ODD, 1'b0, 12'b0_11101001010, 11, 1'b0);
        wait_frame();

        // 8N2 0x00
        @(posedge clk); #1;
        send(8'h00, 8'd4, 1'b0, 1'b0, 1'b1, 12'b0_11000000000, 11, 1'b0);
        wait_frame();

        // Divisor 0 is refused; switching to 5 gets accepted (8O2 0x5A)
        @(posedge clk); #1;
        cfg_div = 8'd0; tx_data = 8'h5A; cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b1; cfg_stop2 = 1'b1; tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1("div0_ready", tx_ready, 1'b0);
            chk1("div0_txd", txd, 1'b1);
        end
        @(posedge clk); #1;
        send(8'h5A, 8'd5, 1'b1, 1'b1, 1'b1, 12'b111010110100, 12, 1'b0);
        wait_frame();

        // Abort during data bit 3 of 0x3C
        @(posedge clk); #1;
        send(8'h3C, 8'd5, 1'b0, 1'b0, 1'b0, 12'b00_1001111000, 10, 1'b1);
        count_ticks(70);
        tx_abort = 1'b1;
        @(posedge clk); #1; tx_abort = 1'b0;
        ready_seq("after_abort");

        // Abort in idle does nothing
        @(posedge clk); #1; tx_abort = 1'b1;
        @(negedge clk);
        chk1("idle_abort_ready", tx_ready, 1'b1);
        @(posedge clk); #1; tx_abort = 1'b0;
        @(negedge clk);
        chk1("idle_abort_txd", txd, 1'b1);
        chk1("idle_abort_busy", busy, 1'b0);

        // Asynchronous reset in STOP1, between clock edges
        @(posedge clk); #1;
        send(8'hA5, 8'd3, 1'b0, 1'b0, 1'b0, 12'b00_1101001010, 10, 1'b1);
        count_ticks(150);
        #2; rst = 1'b1;
        #1;
        chk1("async_rst_txd", txd, 1'b1);
        chk1("async_rst_baud_en", baud_en, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        @(posedge clk);
        @(posedge clk); #1; rst = 1'b0;
        ready_seq("after_async_rst");

        // Back-to-back frames with tx_valid re-asserted immediately
        @(posedge clk); #1;
        send(8'hFF, 8'd3, 1'b0, 1'b0, 1'b0, 12'b00_1111111110, 10, 1'b0);
        send(8'h01, 8'd3, 1'b0, 1'b0, 1'b0, 12'b00_1000000010, 10, 1'b0);
        wait_frame();

        for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
